// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic array.
// Holds the sequencer states and width/length derivations used by the array.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic int row_idx_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 2;
    endfunction

    // Sign-extend the low w bits of v across all 64 bits.
    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = signed'(v << (64 - w));
        return t >>> (64 - w);
    endfunction

endpackage

// File: rtl/systolic_mm_array_if.sv
// Operand stream and result row stream of the systolic array.
// master is the datapath neighbour side, slave is the array side.
interface systolic_mm_array_if
    import systolic_pkg::*;
#(
    parameter int W     = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int ACC_W = 24
);
    localparam int RI_W = row_idx_w(ROWS);

    logic                    in_valid;
    logic                    in_ready;
    logic [ROWS*W-1:0]       a_vec;
    logic [COLS*W-1:0]       b_vec;
    logic                    out_valid;
    logic                    out_ready;
    logic [COLS*ACC_W-1:0]   out_row;
    logic [RI_W-1:0]         out_row_idx;

    modport master (
        output in_valid, a_vec, b_vec, out_ready,
        input  in_ready, out_valid, out_row, out_row_idx
    );

    modport slave (
        input  in_valid, a_vec, b_vec, out_ready,
        output in_ready, out_valid, out_row, out_row_idx
    );
endinterface

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell of the output-stationary array.
// Operands march right (a) and down (b) one cell per advance step.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                adv,
    input  logic                clr,
    input  logic signed [W-1:0] a_in,
    input  logic signed [W-1:0] b_in,
    output logic signed [W-1:0] a_out,
    output logic signed [W-1:0] b_out,
    output logic [ACC_W-1:0]    acc
);
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [ACC_W-1:0] acc_q;
    logic [2*W-1:0]   prod;

    assign prod  = (2*W)'(a_in) * (2*W)'(b_in);
    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

    // Accumulate on each advance step and forward operands to neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (clr) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (adv) begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc_q <= acc_q + ACC_W'(sext(64'(prod), 2*W));
        end
    end
endmodule

// File: rtl/systolic_mm_array.sv
// ROWS x COLS output-stationary matrix-multiply array with sequencer.
// Skews A/B inputs, accumulates C in the PEs, then drains one row per beat.
module systolic_mm_array
    import systolic_pkg::*;
#(
    parameter int W     = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int ACC_W = 24,
    parameter int K_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [K_W-1:0]     k_len,
    output logic               busy,
    output logic               done,
    systolic_mm_array_if.slave s
);
    localparam int RI_W   = row_idx_w(ROWS);
    localparam int FL_LEN = flush_len(ROWS, COLS);
    localparam int FL_W   = row_idx_w(FL_LEN);

    state_t            state_q;
    logic [K_W-1:0]    k_q;
    logic [K_W-1:0]    k_d;
    logic [K_W-1:0]    klen_q;
    logic [FL_W-1:0]   fl_q;
    logic [RI_W-1:0]   idx_q;
    logic              done_q;
    logic              adv;
    logic              clr;

    logic [W-1:0]      a_h [ROWS][COLS+1];
    logic [W-1:0]      b_v [ROWS+1][COLS];
    logic [ACC_W-1:0]  acc [ROWS][COLS];
    logic [ROWS*W-1:0] a_edge_unused;
    logic [COLS*W-1:0] b_edge_unused;

    assign k_d = k_q + 1'b1;
    assign adv = (state_q == FEED && s.in_valid) || state_q == FLUSH;
    assign clr = state_q == IDLE && start;

    assign busy          = state_q != IDLE;
    assign done          = done_q;
    assign s.in_ready    = state_q == FEED;
    assign s.out_valid   = state_q == DRAIN;
    assign s.out_row_idx = idx_q;

    // Sequencer: capture job, count k-steps, flush the skew, drain rows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            klen_q  <= '0;
            fl_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (start) begin
                    klen_q  <= k_len;
                    k_q     <= '0;
                    fl_q    <= '0;
                    idx_q   <= '0;
                    state_q <= (k_len == '0) ? DRAIN : FEED;
                end
                FEED: if (s.in_valid) begin
                    k_q <= k_d;
                    if (k_d == klen_q)
                        state_q <= (FL_LEN == 0) ? DRAIN : FLUSH;
                end
                FLUSH: begin
                    fl_q <= fl_q + 1'b1;
                    if (fl_q == FL_W'(FL_LEN - 1))
                        state_q <= DRAIN;
                end
                DRAIN: if (s.out_ready) begin
                    if (idx_q == RI_W'(ROWS - 1)) begin
                        idx_q   <= '0;
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        logic [W-1:0] a_src;
        assign a_src = (state_q == FEED) ? s.a_vec[r*W +: W] : '0;
        assign a_edge_unused[r*W +: W] = a_h[r][COLS];
        if (r == 0) begin : g_direct
            assign a_h[r][0] = a_src;
        end else begin : g_chain
            logic [W-1:0] sk_q [r];
            // Delay A element r by r advance steps.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < r; i++) sk_q[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < r; i++) sk_q[i] <= '0;
                end else if (adv) begin
                    sk_q[0] <= a_src;
                    for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
                end
            end
            assign a_h[r][0] = sk_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_bskew
        logic [W-1:0] b_src;
        assign b_src = (state_q == FEED) ? s.b_vec[c*W +: W] : '0;
        assign b_edge_unused[c*W +: W] = b_v[ROWS][c];
        assign s.out_row[c*ACC_W +: ACC_W] = acc[idx_q][c];
        if (c == 0) begin : g_direct
            assign b_v[0][c] = b_src;
        end else begin : g_chain
            logic [W-1:0] sk_q [c];
            // Delay B element c by c advance steps.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < c; i++) sk_q[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < c; i++) sk_q[i] <= '0;
                end else if (adv) begin
                    sk_q[0] <= b_src;
                    for (int i = 1; i < c; i++) sk_q[i] <= sk_q[i-1];
                end
            end
            assign b_v[0][c] = sk_q[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            systolic_pe #(.W(W), .ACC_W(ACC_W)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .adv   (adv),
                .clr   (clr),
                .a_in  (a_h[r][c]),
                .b_in  (b_v[r][c]),
                .a_out (a_h[r][c+1]),
                .b_out (b_v[r+1][c]),
                .acc   (acc[r][c])
            );
        end
    end
endmodule
